// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the kappa3-light memory responder.
// Holds the FSM state encoding, the I/O register offsets and the store-lane legality check.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [3:0] IO_LED = 4'h0;
    localparam logic [3:0] IO_SW  = 4'h4;
    localparam logic [3:0] IO_CYC = 4'h8;

    // Only naturally aligned byte, half and word lane patterns are legal stores.
    function automatic logic wrbits_legal(input logic [3:0] wb);
        logic ok;
        case (wb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_responder_sync_ram.sv
// Word RAM with a byte-enabled write port and a registered read port.
// Contents are intentionally not reset.
module sync_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Lane-masked write and read-before-write registered read.
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves core load/store strobes from a word RAM or a small
// I/O window (LED, switches, cycle counter) and answers with a one-cycle mem_ready pulse.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          DEPTH   = 4096,
    parameter int          RD_LAT  = 2,
    parameter int          WR_LAT  = 1,
    parameter logic [31:0] IO_BASE = 32'hFFFF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_wrbits,
    input  logic [31:0] addr,
    input  logic [31:0] wrdata,
    output logic [31:0] rddata,
    output logic        mem_ready,
    output logic        mem_err,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_cnt;
    logic [AW-1:0] r_word;
    logic [3:0]    r_wrbits;
    logic [31:0]   r_wrdata;
    logic          r_wr;
    logic          r_ram;
    logic          r_err;
    logic [3:0]    r_off;
    logic [31:0]   r_rddata;
    logic          r_ready;
    logic          r_err_o;
    logic [15:0]   r_led;
    logic [31:0]   r_cycle;
    logic [15:0]   r_sw_m;
    logic [15:0]   r_sw_s;

    logic          w_in_ram;
    logic          w_in_io;
    logic [31:0]   w_io_rel;
    logic [3:0]    w_io_off;
    logic          w_req_err;
    logic [2:0]    w_load;
    logic [31:0]   w_io_q;
    logic [31:0]   w_ram_q;
    logic          w_ram_we;
    logic          w_accept;

    // Request decode on the incoming address; the result is latched at acceptance.
    always_comb begin
        w_in_ram  = (addr < RAM_BYTES);
        w_io_rel  = addr - IO_BASE;
        w_in_io   = (addr >= IO_BASE) && (w_io_rel < 32'd16);
        w_io_off  = {w_io_rel[3:2], 2'b00};
        w_req_err = (mem_read && mem_write)
                 || (!w_in_ram && !w_in_io)
                 || (w_in_io && (w_io_off != IO_LED) && (w_io_off != IO_SW) && (w_io_off != IO_CYC))
                 || (mem_write && !wrbits_legal(mem_wrbits));
        if (w_req_err || !w_in_ram) begin
            w_load = 3'd1;
        end else if (mem_write) begin
            w_load = 3'(WR_LAT);
        end else begin
            w_load = 3'(RD_LAT);
        end
    end

    // Next-state logic; the counter hits zero one edge before DONE, giving L+1 cycles.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (mem_read || mem_write) w_next = BUSY;
                else                       w_next = IDLE;
            end
            BUSY: begin
                if (r_cnt == 3'd0) w_next = DONE;
                else               w_next = BUSY;
            end
            DONE:    w_next = HOLD;
            HOLD: begin
                if (!mem_read && !mem_write) w_next = IDLE;
                else                         w_next = HOLD;
            end
            default: w_next = IDLE;
        endcase
    end

    // I/O read mux and RAM write strobe for the latched request.
    always_comb begin
        case (r_off)
            IO_LED:  w_io_q = {16'h0000, r_led};
            IO_SW:   w_io_q = {16'h0000, r_sw_s};
            IO_CYC:  w_io_q = r_cycle;
            default: w_io_q = 32'h0000_0000;
        endcase
        w_accept = (r_state == IDLE) && (w_next == BUSY);
        w_ram_we = (r_state == DONE) && r_ram && r_wr && !r_err;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Request latch, latency counter, completion outputs and I/O registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= 3'd0;
            r_word   <= '0;
            r_wrbits <= 4'h0;
            r_wrdata <= 32'h0000_0000;
            r_wr     <= 1'b0;
            r_ram    <= 1'b0;
            r_err    <= 1'b0;
            r_off    <= 4'h0;
            r_rddata <= 32'h0000_0000;
            r_ready  <= 1'b0;
            r_err_o  <= 1'b0;
            r_led    <= 16'h0000;
            r_cycle  <= 32'h0000_0000;
            r_sw_m   <= 16'h0000;
            r_sw_s   <= 16'h0000;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            r_sw_m  <= sw_in;
            r_sw_s  <= r_sw_m;
            if (w_accept) begin
                r_cnt    <= w_load;
                r_word   <= addr[AW+1:2];
                r_wrbits <= mem_wrbits;
                r_wrdata <= wrdata;
                r_wr     <= mem_write;
                r_ram    <= w_in_ram;
                r_err    <= w_req_err;
                r_off    <= w_io_off;
            end else if ((r_state == BUSY) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_next == DONE) begin
                r_ready <= 1'b1;
                r_err_o <= r_err;
                if (r_err) begin
                    r_rddata <= 32'h0000_0000;
                end else if (!r_wr) begin
                    r_rddata <= r_ram ? w_ram_q : w_io_q;
                end
            end else begin
                r_ready <= 1'b0;
                r_err_o <= 1'b0;
            end
            if ((r_state == DONE) && !r_ram && r_wr && !r_err && (r_off == IO_LED)) begin
                if (r_wrbits[0]) r_led[7:0]  <= r_wrdata[7:0];
                if (r_wrbits[1]) r_led[15:8] <= r_wrdata[15:8];
            end
        end
    end

    sync_ram #(.DEPTH(DEPTH)) u_ram (
        .i_clk   (clock),
        .i_we    (w_ram_we),
        .i_be    (r_wrbits),
        .i_addr  (r_word),
        .i_wdata (r_wrdata),
        .o_rdata (w_ram_q)
    );

    assign rddata    = r_rddata;
    assign mem_ready = r_ready;
    assign mem_err   = r_err_o;
    assign led_out   = r_led;

endmodule

// File: tb/tb_mem_responder.sv
// Directed-vector bench for mem_responder (DEPTH=4096, RD_LAT=2, WR_LAT=1).
module tb_mem_responder;

    localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wrbits;
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [31:0] rddata;
    logic        mem_ready;
    logic        mem_err;
    logic [15:0] sw_in;
    logic [15:0] led_out;

    int   n_vec  = 0;
    int   n_miss = 0;
    int   tb_cyc = 0;
    int   pulses = 0;
    logic stray  = 1'b0;

    mem_responder dut (
        .clock      (clock),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wrbits (mem_wrbits),
        .addr       (addr),
        .wrdata     (wrdata),
        .rddata     (rddata),
        .mem_ready  (mem_ready),
        .mem_err    (mem_err),
        .sw_in      (sw_in),
        .led_out    (led_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) tb_cyc <= tb_cyc + 1;

    always @(negedge clock) begin
        if (mem_ready) pulses = pulses + 1;
        if (!mem_ready && mem_err) stray = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, scramble inputs after acceptance, wait for mem_ready.
    task automatic req(input logic rd, input logic wr, input logic [3:0] wb,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] q, output logic e, output int lat);
        int n;
        n = 0;
        mem_read = rd; mem_write = wr; mem_wrbits = wb; addr = a; wrdata = d;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) begin
                addr = ~a; wrdata = ~d; mem_wrbits = ~wb;
            end
        end while (!mem_ready && n < 30);
        if (!mem_ready) chk("ready_timeout", {31'b0, mem_ready}, 32'd1);
        q = rddata; e = mem_err; lat = n - 1;
        mem_read = 1'b0; mem_write = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic do_wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] wb, input int exp_lat);
        logic [31:0] q; logic e; int lat;
        req(1'b0, 1'b1, wb, a, d, q, e, lat);
        chk({tag, "_err"}, {31'b0, e}, 32'd0);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic do_rd(input string tag, input logic [31:0] a, input logic [31:0] exp_q,
                         input int exp_lat);
        logic [31:0] q; logic e; int lat;
        req(1'b1, 1'b0, 4'h0, a, 32'h0, q, e, lat);
        chk({tag, "_data"}, q, exp_q);
        chk({tag, "_err"}, {31'b0, e}, 32'd0);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic do_bad(input string tag, input logic rd, input logic wr, input logic [3:0] wb,
                          input logic [31:0] a);
        logic [31:0] q; logic e; int lat;
        req(rd, wr, wb, a, 32'hFFFF_FFFF, q, e, lat);
        chk({tag, "_err"}, {31'b0, e}, 32'd1);
        chk({tag, "_data"}, q, 32'h0);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
    endtask

    initial begin
        logic [31:0] q, v1, v2;
        logic        e;
        int          lat, c1, c2, p0, n;

        reset = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_wrbits = 4'h0;
        addr = 32'h0; wrdata = 32'h0; sw_in = 16'h0000;
        repeat (3) @(negedge clock);
        chk("rst_ready", {31'b0, mem_ready}, 32'd0);
        chk("rst_err", {31'b0, mem_err}, 32'd0);
        chk("rst_rddata", rddata, 32'h0);
        chk("rst_led", {16'h0, led_out}, 32'h0);
        reset = 1'b1;
        @(negedge clock);

        // RAM word write/read and latencies
        do_wr("w_deadbeef", 32'h100, 32'hDEAD_BEEF, 4'b1111, 2);
        do_rd("r_deadbeef", 32'h100, 32'hDEAD_BEEF, 3);

        // Byte and half merges
        do_wr("w_clr", 32'h100, 32'h0000_0000, 4'b1111, 2);
        do_wr("w_sb", 32'h102, 32'h00AA_0000, 4'b0100, 2);
        do_rd("r_sb", 32'h100, 32'h00AA_0000, 3);
        do_wr("w_sh", 32'h100, 32'h0000_1234, 4'b0011, 2);
        do_rd("r_sh", 32'h100, 32'h00AA_1234, 3);

        // Error cases leave RAM untouched
        do_wr("w_zero", 32'h0, 32'h1122_3344, 4'b1111, 2);
        do_bad("e_wrbits", 1'b0, 1'b1, 4'b0101, 32'h0);
        do_rd("r_zero", 32'h0, 32'h1122_3344, 3);
        do_bad("e_unmapped", 1'b1, 1'b0, 4'h0, 32'h0000_4000);
        do_bad("e_rdwr", 1'b1, 1'b1, 4'b1111, 32'h100);
        do_rd("r_after_rdwr", 32'h100, 32'h00AA_1234, 3);
        do_bad("e_io_c", 1'b1, 1'b0, 4'h0, IO_BASE + 32'hC);

        // LED register: lanes 2-3 ignored, lanes 0-1 byte-enabled
        do_wr("w_led", IO_BASE, 32'hABCD_5A5A, 4'b1111, 2);
        chk("led_out", {16'h0, led_out}, 32'h0000_5A5A);
        do_rd("r_led", IO_BASE, 32'h0000_5A5A, 2);
        do_wr("w_led_hi", IO_BASE, 32'h0000_C300, 4'b0010, 2);
        chk("led_out_hi", {16'h0, led_out}, 32'h0000_C35A);

        // Switch input through the synchronizer; writes are harmless
        sw_in = 16'h0F0F;
        repeat (2) @(negedge clock);
        do_rd("r_sw", IO_BASE + 32'h4, 32'h0000_0F0F, 2);
        do_wr("w_sw", IO_BASE + 32'h4, 32'hFFFF_FFFF, 4'b1111, 2);

        // Cycle counter reads differ by issue distance
        c1 = tb_cyc;
        req(1'b1, 1'b0, 4'h0, IO_BASE + 32'h8, 32'h0, v1, e, lat);
        repeat (3) @(negedge clock);
        c2 = tb_cyc;
        req(1'b1, 1'b0, 4'h0, IO_BASE + 32'h8, 32'h0, v2, e, lat);
        chk("cyc_delta", v2 - v1, 32'(c2 - c1));
        do_wr("w_cyc", IO_BASE + 32'h8, 32'h0, 4'b1111, 2);

        // Held read strobe yields exactly one pulse
        p0 = pulses;
        mem_read = 1'b1; addr = 32'h100; n = 0;
        do begin @(negedge clock); n++; end while (!mem_ready && n < 30);
        repeat (10) @(negedge clock);
        mem_read = 1'b0;
        repeat (4) @(negedge clock);
        chk("held_pulses", 32'(pulses - p0), 32'd1);

        // Reset during BUSY aborts the write
        do_wr("w_old200", 32'h200, 32'hCAFE_F00D, 4'b1111, 2);
        p0 = pulses;
        mem_write = 1'b1; mem_wrbits = 4'b1111; addr = 32'h200; wrdata = 32'h1234_5678;
        @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        mem_write = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        chk("abort_pulses", 32'(pulses - p0), 32'd0);
        chk("abort_ready", {31'b0, mem_ready}, 32'd0);
        chk("abort_led", {16'h0, led_out}, 32'h0);
        do_rd("r_old200", 32'h200, 32'hCAFE_F00D, 3);

        chk("err_only_with_ready", {31'b0, stray}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
